// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and RV32M divide corner-case constants
// used by the divider sequencing stage (div_ctrl) and its fixup selector.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } div_state_t;

  localparam int DIV_XLEN = 32;

  // Wait counter wide enough for a multicycle window of up to 15 cycles
  localparam int DIV_CNT_W = 4;

  // Quotient defined for a zero divisor, and the most negative dividend
  localparam logic [DIV_XLEN-1:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [DIV_XLEN-1:0] DIV_INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/div_fixup.sv
// div_fixup: combinational selector that replaces the raw divider result
// with the RISC-V architectural value for a zero divisor or for the
// INT_MIN / -1 overflow. When DIV_FASTPATH_EN is defined it also produces
// the trivial results for a divisor of one and a dividend of zero, so the
// fast path in div_ctrl can bypass the divider entirely.
// The constants assume XLEN = 32 (RV32M).
module div_fixup
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] i_operA,
  input  logic [XLEN-1:0] i_operB,
  input  logic            i_opDiv,
  input  logic [XLEN-1:0] i_divO,
  output logic [XLEN-1:0] o_result,
  output logic            o_dz
);

  localparam logic [XLEN-1:0] ALL_ONES_C = XLEN'(DIV_ALL_ONES);
  localparam logic [XLEN-1:0] INT_MIN_C  = XLEN'(DIV_INT_MIN);
`ifdef DIV_FASTPATH_EN
  localparam logic [XLEN-1:0] ONE_C      = XLEN'(1);
`endif

  // Priority selection: zero divisor first, then signed overflow, then
  // (fast path builds only) the trivial operands, else the divider output.
  always_comb begin
    o_result = i_divO;
    o_dz     = 1'b0;
    if (i_operB == '0) begin
      o_dz     = 1'b1;
      o_result = i_opDiv ? ALL_ONES_C : i_operA;
    end else if ((i_operA == INT_MIN_C) && (i_operB == ALL_ONES_C)) begin
      o_result = i_opDiv ? INT_MIN_C : '0;
    end
`ifdef DIV_FASTPATH_EN
    else if (i_operB == ONE_C) begin
      o_result = i_opDiv ? i_operA : '0;
    end else if (i_operA == '0) begin
      o_result = '0;
    end
`endif
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequencing and result stage around the combinational signed
// divider of the RV32M execute path. Latches one DIV/REM request, holds the
// operands stable while the divider settles over a DIV_WAIT-cycle window,
// registers the fixed-up result and offers it to writeback with a
// valid/ready handshake. busy stalls issue for the whole transaction.
// Optional build macro DIV_FASTPATH_EN: requests with a zero or unit
// divisor, or a zero dividend, complete straight from IDLE without ever
// enabling the divider.
module div_ctrl
  import div_pkg::*;
#(
  parameter int DIV_WAIT = 2,
  parameter int XLEN     = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op_div,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  output logic            busy,
  output logic            enable_div,
  output logic [XLEN-1:0] oper_a,
  output logic [XLEN-1:0] oper_b,
  output logic            fuct3,
  input  logic [XLEN-1:0] div_o,
  input  logic            div_finish,
  input  logic            divided_by_zero,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            dz_flag
);

  // Counter value on the last cycle of the multicycle window
  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_WAIT - 1);

  div_state_t           r_state;
  div_state_t           w_nextState;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [DIV_CNT_W-1:0] w_cntNext;
  logic                 w_load;
  logic                 w_capture;

  logic [XLEN-1:0]      r_operA;
  logic [XLEN-1:0]      r_operB;
  logic                 r_opDiv;
  logic [4:0]           r_rd;
  logic [XLEN-1:0]      r_wbData;
  logic [4:0]           r_wbRd;
  logic                 r_dz;

  logic                 w_fastHit;
  logic [XLEN-1:0]      w_fixA;
  logic [XLEN-1:0]      w_fixB;
  logic                 w_fixOp;
  logic [4:0]           w_captureRd;
  logic [XLEN-1:0]      w_fixResult;
  logic                 w_fixDz;

`ifdef DIV_FASTPATH_EN
  // In IDLE the fixup sees the live request so a fast-path result can be
  // registered at the same edge that accepts it; otherwise the latched copy.
  assign w_fastHit   = (in_b == '0) || (in_b == XLEN'(1)) || (in_a == '0);
  assign w_fixA      = (r_state == IDLE) ? in_a   : r_operA;
  assign w_fixB      = (r_state == IDLE) ? in_b   : r_operB;
  assign w_fixOp     = (r_state == IDLE) ? op_div : r_opDiv;
  assign w_captureRd = (r_state == IDLE) ? in_rd  : r_rd;
`else
  assign w_fastHit   = 1'b0;
  assign w_fixA      = r_operA;
  assign w_fixB      = r_operB;
  assign w_fixOp     = r_opDiv;
  assign w_captureRd = r_rd;
`endif

  div_fixup #(
    .XLEN(XLEN)
  ) u_fixup (
    .i_operA (w_fixA),
    .i_operB (w_fixB),
    .i_opDiv (w_fixOp),
    .i_divO  (div_o),
    .o_result(w_fixResult),
    .o_dz    (w_fixDz)
  );

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the load/capture strobes for the datapath.
  // The wait counter saturates on the last window cycle so a slow divider
  // is sampled on the first cycle it reports done.
  always_comb begin
    w_nextState = r_state;
    w_cntNext   = r_cnt;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load    = 1'b1;
          w_cntNext = '0;
          if (w_fastHit) begin
            w_capture   = 1'b1;
            w_nextState = DONE;
          end else begin
            w_nextState = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (r_cnt == CNT_LAST) begin
          if (div_finish) begin
            w_capture   = 1'b1;
            w_nextState = DONE;
          end
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      DONE: begin
        if (wb_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand latch, wait counter and result register. Operands only change
  // when a request is accepted, so they stay stable through ISSUE and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_operA  <= '0;
      r_operB  <= '0;
      r_opDiv  <= 1'b0;
      r_rd     <= '0;
      r_wbData <= '0;
      r_wbRd   <= '0;
      r_dz     <= 1'b0;
    end else begin
      r_cnt <= w_cntNext;
      if (w_load) begin
        r_operA <= in_a;
        r_operB <= in_b;
        r_opDiv <= op_div;
        r_rd    <= in_rd;
      end
      if (w_capture) begin
        r_wbData <= w_fixResult;
        r_wbRd   <= w_captureRd;
        r_dz     <= w_fixDz;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign enable_div = (r_state == ISSUE);
  assign wb_valid   = (r_state == DONE);
  assign oper_a     = r_operA;
  assign oper_b     = r_operB;
  assign fuct3      = r_opDiv;
  assign wb_data    = r_wbData;
  assign wb_rd      = r_wbRd;
  assign dz_flag    = r_dz;

  // The divider's own zero flag is not used for data; it must still agree
  // with the latched divisor whenever the divider reports completion.
  property p_dzConsistent;
    @(posedge clk) disable iff (rst)
      ((r_state == ISSUE) && div_finish) |-> (divided_by_zero == (r_operB == '0));
  endproperty
  a_dzConsistent: assert property (p_dzConsistent);

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl. A behavioural stand-in for
// the combinational divider drives div_o/div_finish with a selectable
// completion delay. Checks a hand-written vector table, randomized requests
// against an arithmetic reference model, writeback backpressure and reset
// abort. Honours DIV_FASTPATH_EN when the design is built with it.
module tb_div_ctrl;
  import div_pkg::*;

  localparam int WAIT = 2;

`ifdef DIV_FASTPATH_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_div;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        busy;
  logic        enable_div;
  logic [31:0] oper_a;
  logic [31:0] oper_b;
  logic        fuct3;
  logic [31:0] div_o;
  logic        div_finish;
  logic        divided_by_zero;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        dz_flag;

  int vecCount  = 0;
  int missCount = 0;
  int finLat    = 1;
  int issueCnt  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [4:0]  rd;
    int          lat;
    int          hold;
    logic [31:0] expData;
    logic        expDz;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rop;

  always #5 clk = ~clk;

  div_ctrl #(
    .DIV_WAIT(WAIT),
    .XLEN    (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op_div         (op_div),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_rd          (in_rd),
    .busy           (busy),
    .enable_div     (enable_div),
    .oper_a         (oper_a),
    .oper_b         (oper_b),
    .fuct3          (fuct3),
    .div_o          (div_o),
    .div_finish     (div_finish),
    .divided_by_zero(divided_by_zero),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_data        (wb_data),
    .wb_rd          (wb_rd),
    .dz_flag        (dz_flag)
  );

  // Counts how many cycles the divider has already been enabled
  always @(posedge clk) begin
    if (enable_div) issueCnt <= issueCnt + 1;
    else            issueCnt <= 0;
  end

  // Divider stand-in: raw signed quotient/remainder, junk for the corner
  // cases so that only a correct fixup produces the architectural value
  always_comb begin
    int sa;
    int sb;
    div_o = 32'h1234_5678;
    sa    = oper_a;
    sb    = oper_b;
    if ((oper_b != 32'd0) && !((oper_a == DIV_INT_MIN) && (oper_b == DIV_ALL_ONES))) begin
      if (fuct3) div_o = 32'(sa / sb);
      else       div_o = 32'(sa % sb);
    end
  end

  assign div_finish      = enable_div && ((issueCnt + 1) >= finLat);
  assign divided_by_zero = (oper_b == 32'd0);

  // Architectural DIV/REM result straight from the RISC-V rules
  function automatic logic [31:0] refResult(logic [31:0] a, logic [31:0] b, logic isDiv);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return isDiv ? 32'hFFFF_FFFF : a;
    if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return isDiv ? 32'h8000_0000 : 32'd0;
    if (isDiv) return 32'(sa / sb);
    return 32'(sa % sb);
  endfunction

  function automatic bit isFast(logic [31:0] a, logic [31:0] b);
    bit hit;
    hit = (b == 32'd0) || (b == 32'd1) || (a == 32'd0);
    return hit && FAST_EN;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One full request: issue, wait for wb_valid, optional backpressure with
  // a stray start, then handshake and confirm the stage is idle again
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic op, input logic [4:0] rd, input int lat,
                               input int hold, input logic [31:0] expData, input logic expDz);
    int expLat;
    int seen;
    int enCount;
    bit fast;
    fast    = isFast(a, b);
    expLat  = fast ? 1 : (((lat > WAIT) ? lat : WAIT) + 1);
    finLat  = lat;
    wb_ready = (hold == 0);
    seen    = 0;
    enCount = 0;
    @(negedge clk);
    start  = 1'b1;
    in_a   = a;
    in_b   = b;
    op_div = op;
    in_rd  = rd;
    for (int k = 1; (k <= 40) && (seen == 0); k++) begin
      @(negedge clk);
      if (enable_div) enCount++;
      if (wb_valid) seen = k;
      if ((k == 1) && !fast) begin
        checkOutput({tag, " oper_a"}, oper_a, a);
        checkOutput({tag, " oper_b"}, oper_b, b);
        checkOutput({tag, " fuct3"}, 32'(fuct3), 32'(op));
      end
      if (k == 1) begin
        start  = 1'b0;
        in_a   = $urandom;
        in_b   = $urandom;
        op_div = ~op;
        in_rd  = ~rd;
      end
    end
    if (seen == 0) begin
      checkOutput({tag, " wb_valid timeout"}, 32'd0, 32'd1);
      start    = 1'b0;
      wb_ready = 1'b1;
      return;
    end
    checkOutput({tag, " latency"}, 32'(seen), 32'(expLat));
    checkOutput({tag, " enable cycles"}, 32'(enCount), 32'(expLat - 1));
    checkOutput({tag, " wb_data"}, wb_data, expData);
    checkOutput({tag, " wb_rd"}, 32'(wb_rd), 32'(rd));
    checkOutput({tag, " dz_flag"}, 32'(dz_flag), 32'(expDz));
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      checkOutput({tag, " hold wb_valid"}, 32'(wb_valid), 32'd1);
      checkOutput({tag, " hold wb_data"}, wb_data, expData);
      checkOutput({tag, " hold busy"}, 32'(busy), 32'd1);
      if ((h == 1) && (hold >= 2)) begin
        start  = 1'b1;
        in_a   = 32'd77;
        in_b   = 32'd0;
        op_div = 1'b1;
        in_rd  = 5'd31;
      end else begin
        start = 1'b0;
      end
    end
    wb_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, " post-handshake busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " post-handshake wb_valid"}, 32'(wb_valid), 32'd0);
    start = 1'b0;
  endtask

  // Reset checks: every output at zero
  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " enable_div"}, 32'(enable_div), 32'd0);
    checkOutput({tag, " wb_valid"}, 32'(wb_valid), 32'd0);
    checkOutput({tag, " dz_flag"}, 32'(dz_flag), 32'd0);
    checkOutput({tag, " fuct3"}, 32'(fuct3), 32'd0);
    checkOutput({tag, " oper_a"}, oper_a, 32'd0);
    checkOutput({tag, " oper_b"}, oper_b, 32'd0);
    checkOutput({tag, " wb_data"}, wb_data, 32'd0);
    checkOutput({tag, " wb_rd"}, 32'(wb_rd), 32'd0);
  endtask

  // Reset in the middle of DIV 9/3, then reset colliding with start
  task automatic resetAbort();
    int validSeen;
    wb_ready = 1'b1;
    finLat   = 1;
    @(negedge clk);
    start  = 1'b1;
    in_a   = 32'd9;
    in_b   = 32'd3;
    op_div = 1'b1;
    in_rd  = 5'd9;
    @(negedge clk);
    checkOutput("abort in-flight busy", 32'(busy), 32'd1);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    checkAllZero("abort");
    start = 1'b1;
    @(negedge clk);
    checkOutput("rst over start busy", 32'(busy), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    validSeen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wb_valid) validSeen++;
    end
    checkOutput("abort no wb_valid", 32'(validSeen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    op_div   = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_rd    = '0;
    wb_ready = 1'b0;

    tbl[0]  = '{32'd100,       32'd7,          1'b1, 5'd1,  1, 0, 32'd14,         1'b0};
    tbl[1]  = '{32'hFFFF_FF9C, 32'd7,          1'b0, 5'd2,  1, 0, 32'hFFFF_FFFE,  1'b0};
    tbl[2]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9,  1'b1, 5'd3,  1, 0, 32'd14,         1'b0};
    tbl[3]  = '{32'd5,         32'd0,          1'b1, 5'd4,  1, 0, 32'hFFFF_FFFF,  1'b1};
    tbl[4]  = '{32'd5,         32'd0,          1'b0, 5'd5,  1, 0, 32'd5,          1'b1};
    tbl[5]  = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 5'd6,  1, 0, 32'h8000_0000,  1'b0};
    tbl[6]  = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 5'd7,  1, 0, 32'd0,          1'b0};
    tbl[7]  = '{32'd100,       32'd7,          1'b1, 5'd8,  1, 4, 32'd14,         1'b0};
    tbl[8]  = '{32'd1000,      32'd3,          1'b1, 5'd9,  5, 2, 32'd333,        1'b0};
    tbl[9]  = '{32'd7,         32'hFFFF_FFFD,  1'b0, 5'd10, 1, 0, 32'd1,          1'b0};
    tbl[10] = '{32'd42,        32'd1,          1'b1, 5'd11, 1, 0, 32'd42,         1'b0};
    tbl[11] = '{32'd0,         32'd5,          1'b1, 5'd12, 3, 0, 32'd0,          1'b0};

    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].rd,
                    tbl[i].lat, tbl[i].hold, tbl[i].expData, tbl[i].expDz);
    end

    resetAbort();

    for (int n = 0; n < 30; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: rb = 32'd0;
        1: begin ra = DIV_INT_MIN; rb = DIV_ALL_ONES; end
        2: rb = 32'd1;
        3: ra = 32'd0;
        4: begin
          ra = 32'($urandom_range(0, 400)) - 32'd200;
          rb = 32'($urandom_range(0, 20)) - 32'd10;
        end
        default: ;
      endcase
      applyStimulus($sformatf("rnd%0d", n), ra, rb, rop, 5'($urandom_range(0, 31)),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 2)),
                    refResult(ra, rb, rop), (rb == 32'd0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing and result stage wrapped around the combinational signed divider in the RV32M execute path. Accepts one DIV/REM request from the issue stage. Holds the operands stable while the divider evaluates over a configurable multicycle window, then registers the result. Applies the RISC-V divide-by-zero and overflow rules and presents the result to writeback with a valid/ready handshake. Stalls the pipeline via `busy` until writeback accepts.

## Interface
- `DIV_WAIT`, 2: cycles `enable_div` is held before the result is sampled (1..15; multicycle path budget)
- `XLEN`, 32: operand/result width
- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: request pulse from issue stage
- `op_div` in 1: 1 = DIV, 0 = REM (signed)
- `in_a` in XLEN: dividend
- `in_b` in XLEN: divisor
- `in_rd` in 5: destination register tag
- `busy` out 1: request in flight; issue must stall
- `enable_div` out 1: divider enable
- `oper_a`, `oper_b` out XLEN: latched operands to divider
- `fuct3` out 1: latched `op_div` to divider
- `div_o` in XLEN: divider result
- `div_finish` in 1: divider done
- `divided_by_zero` in 1: divider zero flag
- `wb_valid` out 1: result available
- `wb_ready` in 1: writeback accepts
- `wb_data` out XLEN: architectural result
- `wb_rd` out 5: destination tag
- `dz_flag` out 1: result came from a zero divisor

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - On `start`, latch `in_a`, `in_b`, `op_div`, `in_rd`.
  - Clear the wait counter and go to ISSUE.
- ISSUE:
  - `enable_div`=1 and operand outputs are stable.
  - The counter increments each cycle.
  - When the counter = DIV_WAIT-1 and `div_finish`=1, register the fixed-up result and go to DONE.
  - If `div_finish`=0 at that point, stay in ISSUE with the counter saturated and sample on the first cycle `div_finish`=1.
- Fixup, first match wins:
  - `in_b`=0: DIV gives all-ones; REM gives `in_a`; `dz_flag`=1.
  - `in_a`=0x80000000 and `in_b`=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
  - Otherwise `div_o` passes through.
- The fixup uses the latched operands and ignores `divided_by_zero` for data. `divided_by_zero` is only cross-checked by assertion against `oper_b`==0.
- DONE:
  - `wb_valid`=1; `wb_data`, `wb_rd` and `dz_flag` are held stable.
  - When `wb_ready`=1, go to IDLE.
- `busy` = (state != IDLE).
- `start` while `busy`=1 is ignored; the issue stage honours `busy`.
- `enable_div`=0 in IDLE and DONE.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`, `enable_div`, `fuct3`, `wb_valid` and `dz_flag` are 0.
  - `oper_a`, `oper_b`, `wb_data` and `wb_rd` are 0.
- `start` is sampled at edge E0. `enable_div` is high for cycles E0+1 .. E0+DIV_WAIT.
- `wb_valid` rises at E0+DIV_WAIT+1, so minimum latency is DIV_WAIT+1 cycles. With DIV_WAIT=2, latency is 3.
- `wb_valid` stays high until the cycle in which `wb_ready`=1. `busy` drops at the next edge.
- The earliest next `start` is accepted in the cycle after the handshake, giving a throughput of one request per DIV_WAIT+2 cycles.
- `wb_ready`=1 before `wb_valid` has no effect.
- `rst` during ISSUE or DONE:
  - Returns to IDLE at that edge.
  - The in-flight result is discarded and no `wb_valid` is produced.
  - `rst` has priority over `start`.

## Configuration
- `DIV_FASTPATH_EN` defined: in IDLE, a `start` whose `in_b`=0, or `in_b`=1, or `in_a`=0 skips ISSUE.
  - The fixed-up result is registered directly and the FSM goes to DONE; `wb_valid` rises at E0+1.
  - Results for these cases: divisor 1 gives DIV=`in_a`, REM=0; dividend 0 gives 0 for both; divisor 0 is as in the fixup rules.
  - `enable_div` is never asserted for these requests.
- `DIV_FASTPATH_EN` undefined: every request takes the ISSUE path.

## Structure
- Shared package `div_pkg`:
  - State enum `div_state_t` (IDLE, ISSUE, DONE).
  - Constants `DIV_ALL_ONES` and `DIV_INT_MIN`.
- One sub-module, `div_fixup`: a combinational corner-case selector.
  - Inputs: latched operands, `op_div`, `div_o`.
  - Outputs: result and dz.
  - Shared by the ISSUE and fast paths.

## Test plan
- DIV 100/7, DIV_WAIT=2, `wb_ready`=1 → `wb_data`=14; `wb_valid` at E0+3 for one cycle; `enable_div` high exactly 2 cycles.
- REM -100/7 → `wb_data`=0xFFFFFFFE (-2). DIV -100/-7 → 14.
- DIV 5/0 → 0xFFFFFFFF with `dz_flag`=1. REM 5/0 → 5 with `dz_flag`=1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- `wb_ready` held 0 for 4 cycles in DONE:
  - `wb_valid`, `wb_data` and `busy` stay stable.
  - A second `start` during this time is ignored.
  - The request is accepted after release.
- `rst` asserted at E0+1 of DIV 9/3 → IDLE next edge, all outputs 0, no `wb_valid`.
- With `DIV_FASTPATH_EN`, DIV 42/1 → `wb_valid` at E0+1 with `wb_data`=42 and `enable_div` never high.
